// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the final fully-connected classifier layer:
//   DATA_W / FRAC_W : signed Q4.11 data format of activations, weights,
//                     biases and scores
//   N_OUT           : number of class scores produced per run
//   SAT_W           : working width used by the round/saturate helper
//   fc_state_e      : sequencing FSM states
//   sat_round()     : widened accumulator -> rounded, saturated Q4.11 score
// Optional feature macro used by the layer: FC_BIAS_EN (per-neuron bias).
// ---------------------------------------------------------------------------
package fc_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 11;
    localparam int N_OUT  = 10;
    localparam int SAT_W  = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINAL,
        DONE
    } fc_state_e;

    // Takes a Q8.22 sum (already including any bias) held in a wide signed
    // word, rounds half up at the FRAC_W boundary, shifts back to Q4.11 and
    // clamps into the representable 16-bit signed range.
    function automatic logic [DATA_W-1:0] sat_round(input logic signed [SAT_W-1:0] acc);
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] smax;
        logic signed [SAT_W-1:0] smin;
        logic signed [SAT_W-1:0] rounded;
        logic [DATA_W-1:0]       result;
        half    = 64'sd1 <<< (FRAC_W - 1);
        smax    = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
        smin    = -(64'sd1 <<< (DATA_W - 1));
        rounded = acc + half;
        rounded = rounded >>> FRAC_W;
        if (rounded > smax) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (rounded < smin) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = rounded[DATA_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fc_output_layer_mac.sv
// ---------------------------------------------------------------------------
// fc_mac
// Signed multiply-accumulate engine for one neuron at a time.
//   clk, reset   : clock and synchronous active-high reset
//   act_i, wt_i  : Q4.11 activation and weight operands
//   bias_i       : Q4.11 bias folded in when the score is formed
//   acc_en_i     : add act_i*wt_i into the accumulator this cycle
//   acc_clr_i    : clear the accumulator (wins over acc_en_i)
//   result_o     : rounded, saturated Q4.11 score of acc + bias
// ---------------------------------------------------------------------------
module fc_mac
    import fc_pkg::*;
#(
    parameter int ACC_W = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [DATA_W-1:0] wt_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic                     acc_en_i,
    input  logic                     acc_clr_i,
    output logic        [DATA_W-1:0] result_o
);

    logic signed [2*DATA_W-1:0] act_ext;
    logic signed [2*DATA_W-1:0] wt_ext;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [SAT_W-1:0]    final_sum;

    // Operands are sign-extended to the full product width first so the
    // Q8.22 product of two Q4.11 values never loses its upper bits.
    always_comb begin
        act_ext = (2*DATA_W)'(act_i);
        wt_ext  = (2*DATA_W)'(wt_i);
        product = act_ext * wt_ext;
    end

    // Accumulator next-state: clearing takes priority so the FINAL cycle can
    // both read the finished sum and prepare for the following neuron.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + ACC_W'(product);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Bias is aligned to the Q8.22 accumulator by shifting it up FRAC_W bits
    // before the shared round/saturate step.
    always_comb begin
        final_sum = SAT_W'(acc_q) + (SAT_W'(bias_i) <<< FRAC_W);
        result_o  = sat_round(final_sum);
    end

endmodule

// File: rtl/fc_output_layer.sv
// ---------------------------------------------------------------------------
// fc_output_layer
// Last fully-connected layer of the classifier: computes N_OUT class scores by
// serial MAC over N_IN activations and a neuron-major weight ROM.
//   clk, reset            : clock, synchronous active-high reset
//   enable                : level start request (needs low->high to restart)
//   act_addr / act_data   : activation buffer port, 1-cycle read latency
//   wt_addr / wt_data     : weight ROM port (k*N_IN + j), 1-cycle latency
//   bias_addr / bias_data : bias ROM port, only when FC_BIAS_EN is defined
//   score0..score9        : registered Q4.11 class scores
//   done                  : all scores of the current run valid
// Configuration macro: FC_BIAS_EN adds a per-neuron bias; without it the bias
// ports are absent and the bias is zero, with identical latency.
// ---------------------------------------------------------------------------
module fc_output_layer
    import fc_pkg::*;
#(
    parameter int N_IN = 84,
    localparam int AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WAW = $clog2(N_OUT * N_IN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [AW-1:0]     act_addr,
    input  logic [DATA_W-1:0] act_data,
    output logic [WAW-1:0]    wt_addr,
    input  logic [DATA_W-1:0] wt_data,
`ifdef FC_BIAS_EN
    output logic [3:0]        bias_addr,
    input  logic [DATA_W-1:0] bias_data,
`endif
    output logic [DATA_W-1:0] score0,
    output logic [DATA_W-1:0] score1,
    output logic [DATA_W-1:0] score2,
    output logic [DATA_W-1:0] score3,
    output logic [DATA_W-1:0] score4,
    output logic [DATA_W-1:0] score5,
    output logic [DATA_W-1:0] score6,
    output logic [DATA_W-1:0] score7,
    output logic [DATA_W-1:0] score8,
    output logic [DATA_W-1:0] score9,
    output logic              done
);

    localparam int ACC_W = 2*DATA_W + $clog2(N_IN);

    fc_state_e          state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic [AW-1:0]      j_q, j_d;
    logic [WAW-1:0]     wt_addr_q, wt_addr_d;
    logic               done_q, done_d;
    logic               acc_en, acc_clr, score_we;
    logic               last_j, last_k;
    logic [DATA_W-1:0]  bias_val;
    logic [DATA_W-1:0]  mac_result;
    logic [DATA_W-1:0]  score_q [N_OUT];

    assign last_j = (j_q == AW'(N_IN - 1));
    assign last_k = (k_q == 4'(N_OUT - 1));

    // State register. A synchronous reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. enable only matters in IDLE (start) and DONE (leave
    // once it drops), so a held enable cannot retrigger a finished run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = ISSUE;
            ISSUE:   if (last_j) state_d = DRAIN;
            DRAIN:   state_d = FINAL;
            FINAL:   state_d = last_k ? DONE : ISSUE;
            DONE:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs. Memory data lags its address by one cycle, so the
    // first ISSUE cycle of a neuron has nothing to accumulate yet and DRAIN
    // picks up the product of the last address.
    always_comb begin
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        score_we = 1'b0;
        case (state_q)
            IDLE:  acc_clr = 1'b1;
            ISSUE: acc_en  = (j_q != '0);
            DRAIN: acc_en  = 1'b1;
            FINAL: begin
                score_we = 1'b1;
                acc_clr  = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter and address next-state. The weight address simply walks
    // forward because the ROM is neuron-major: the step out of FINAL lands on
    // k*N_IN for the next neuron. done is held only while the FSM stays in
    // DONE, so it drops on the same edge the FSM returns to IDLE.
    always_comb begin
        k_d       = k_q;
        j_d       = j_q;
        wt_addr_d = wt_addr_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    k_d       = '0;
                    j_d       = '0;
                    wt_addr_d = '0;
                end
            end
            ISSUE: begin
                if (last_j) begin
                    j_d = '0;
                end else begin
                    j_d       = j_q + AW'(1);
                    wt_addr_d = wt_addr_q + WAW'(1);
                end
            end
            FINAL: begin
                if (!last_k) begin
                    k_d       = k_q + 4'd1;
                    wt_addr_d = wt_addr_q + WAW'(1);
                end
            end
            default: ;
        endcase
        done_d = (state_q == DONE) && (state_d == DONE);
    end

    // Counter, address and done registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q       <= '0;
            j_q       <= '0;
            wt_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            k_q       <= k_d;
            j_q       <= j_d;
            wt_addr_q <= wt_addr_d;
            done_q    <= done_d;
        end
    end

    // Score registers: each neuron's result lands in its own slot at its
    // FINAL edge; untouched slots keep whatever the previous run left.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (score_we && (k_q == 4'(i))) begin
                    score_q[i] <= mac_result;
                end
            end
        end
    end

    // The bias ROM is addressed by the neuron counter itself, which already
    // points at the current neuron well before DRAIN, so bias data is ready
    // in FINAL.
`ifdef FC_BIAS_EN
    assign bias_addr = k_q;
    assign bias_val  = bias_data;
`else
    assign bias_val  = '0;
`endif

    fc_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .act_i     (act_data),
        .wt_i      (wt_data),
        .bias_i    (bias_val),
        .acc_en_i  (acc_en),
        .acc_clr_i (acc_clr),
        .result_o  (mac_result)
    );

    assign act_addr = j_q;
    assign wt_addr  = wt_addr_q;
    assign done     = done_q;
    assign score0   = score_q[0];
    assign score1   = score_q[1];
    assign score2   = score_q[2];
    assign score3   = score_q[3];
    assign score4   = score_q[4];
    assign score5   = score_q[5];
    assign score6   = score_q[6];
    assign score7   = score_q[7];
    assign score8   = score_q[8];
    assign score9   = score_q[9];

endmodule

// File: tb/tb_fc_output_layer.sv
// ---------------------------------------------------------------------------
// tb_fc_output_layer
// Directed, scoreboard-checked bench for fc_output_layer with N_IN=4.
// Behavioural activation/weight/bias memories with one-cycle read latency.
// Build with FC_BIAS_EN defined to exercise the bias ports.
// ---------------------------------------------------------------------------
module tb_fc_output_layer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int RUN_LATENCY = 10 * (N_IN + 2) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  act_addr;
    logic [15:0] act_data;
    logic [5:0]  wt_addr;
    logic [15:0] wt_data;
`ifdef FC_BIAS_EN
    logic [3:0]  bias_addr;
    logic [15:0] bias_data;
`endif
    logic [15:0] score0, score1, score2, score3, score4;
    logic [15:0] score5, score6, score7, score8, score9;
    logic        done;

    logic [15:0] sc [N_OUT];
    logic [15:0] actMem  [N_IN];
    logic [15:0] wtMem   [N_OUT*N_IN];
    logic [15:0] biasMem [N_OUT];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        logic [N_OUT-1:0][15:0] score;
        int                     startEdge;
    } expect_t;

    expect_t expQ[$];
    logic    prevDone = 1'b0;

    fc_output_layer #(
        .N_IN (N_IN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
`ifdef FC_BIAS_EN
        .bias_addr (bias_addr),
        .bias_data (bias_data),
`endif
        .score0    (score0),
        .score1    (score1),
        .score2    (score2),
        .score3    (score3),
        .score4    (score4),
        .score5    (score5),
        .score6    (score6),
        .score7    (score7),
        .score8    (score8),
        .score9    (score9),
        .done      (done)
    );

    assign sc[0] = score0;
    assign sc[1] = score1;
    assign sc[2] = score2;
    assign sc[3] = score3;
    assign sc[4] = score4;
    assign sc[5] = score5;
    assign sc[6] = score6;
    assign sc[7] = score7;
    assign sc[8] = score8;
    assign sc[9] = score9;

    // Free-running clock and an edge counter used to time done.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory models: data follows its address by one edge.
    always @(posedge clk) begin
        act_data <= actMem[act_addr];
        wt_data  <= wtMem[wt_addr];
    end

`ifdef FC_BIAS_EN
    always @(posedge clk) begin
        bias_data <= biasMem[bias_addr];
    end
`endif

    // One comparison: counts it and reports any disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Fill the memories: activation 0 and neuron-0 weights may differ from
    // the rest so the directed cases can be written as a single row.
    task automatic loadMem(input logic [15:0] a0, input logic [15:0] aRest,
                           input logic [15:0] w0, input logic [15:0] wRest,
                           input logic [15:0] b);
        for (int j = 0; j < N_IN; j++) actMem[j] = (j == 0) ? a0 : aRest;
        for (int k = 0; k < N_OUT; k++) begin
            for (int j = 0; j < N_IN; j++) wtMem[k*N_IN + j] = (k == 0) ? w0 : wRest;
            biasMem[k] = b;
        end
    endtask

    // Runs one full inference: queues the expected scores for the monitor,
    // raises enable, waits (bounded) for done, checks done stays up while
    // enable is held and drops after enable is released.
    task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] aRest,
                                 input logic [15:0] w0, input logic [15:0] wRest,
                                 input logic [15:0] b,
                                 input logic [15:0] e0, input logic [15:0] eRest);
        expect_t e;
        logic    seen;
        loadMem(a0, aRest, w0, wRest, b);
        for (int k = 0; k < N_OUT; k++) e.score[k] = (k == 0) ? e0 : eRest;
        @(negedge clk);
        e.startEdge = cyc + 1;
        expQ.push_back(e);
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (!seen) expQ.delete();
        repeat (3) @(negedge clk);
        checkOutput("done_held", 32'(done), 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("done_cleared", 32'(done), 32'd0);
    endtask

    // Monitor: on every rising done, pop the oldest expectation and compare
    // latency and all ten scores. A done with nothing queued is an error.
    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_latency", 32'(cyc - e.startEdge), 32'(RUN_LATENCY));
                    for (int i = 0; i < N_OUT; i++) begin
                        checkOutput($sformatf("score%0d", i), 32'(sc[i]), 32'(e.score[i]));
                    end
                end
            end
            prevDone = done;
        end
    end

    // Stimulus sequence.
    initial begin : stimulus
        int best;
        reset  = 1'b1;
        enable = 1'b1;
        loadMem(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        repeat (5) @(negedge clk);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_act_addr", 32'(act_addr), 32'd0);
        checkOutput("rst_wt_addr", 32'(wt_addr), 32'd0);
        checkOutput("rst_score0", 32'(score0), 32'd0);
        checkOutput("rst_score9", 32'(score9), 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_act_addr", 32'(act_addr), 32'd0);
        checkOutput("idle_wt_addr", 32'(wt_addr), 32'd0);

        $display("[TB] unit activations and weights");
        applyStimulus(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h2000, 16'h2000);

        $display("[TB] neuron 0 dominant");
        applyStimulus(16'h0800, 16'h0800, 16'h1000, 16'h0400, 16'h0000, 16'h4000, 16'h1000);
        best = 0;
        for (int i = 1; i < N_OUT; i++) begin
            if ($signed(sc[i]) > $signed(sc[best])) best = i;
        end
        checkOutput("argmax", 32'(best), 32'd0);

        $display("[TB] reset in the middle of a run");
        loadMem(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000);
        @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_score0", 32'(score0), 32'd0);
        checkOutput("midrst_score1", 32'(score1), 32'd0);
        checkOutput("midrst_score5", 32'(score5), 32'd0);
        checkOutput("midrst_wt_addr", 32'(wt_addr), 32'd0);
        applyStimulus(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h2000, 16'h2000);

        $display("[TB] saturation and rounding");
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF);
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000);
        applyStimulus(16'h0001, 16'h0000, 16'h0400, 16'h0400, 16'h0000, 16'h0001, 16'h0001);
        applyStimulus(16'h0001, 16'h0000, 16'h03FF, 16'h03FF, 16'h0000, 16'h0000, 16'h0000);

        $display("[TB] negative bias");
`ifdef FC_BIAS_EN
        applyStimulus(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'hF800, 16'h1800, 16'h1800);
`else
        applyStimulus(16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'hF800, 16'h2000, 16'h2000);
`endif

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global guard so a stuck design can never hang the run.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
